// File: rtl/memory_stage_pkg.sv
// Shared opcodes, FSM state encoding and default widths for the memory stage.
package memory_stage_pkg;

   localparam int unsigned DATA_W_DEFAULT = 16;

   localparam logic [4:0] OP_ST  = 5'b10000;
   localparam logic [4:0] OP_LD  = 5'b10001;
   localparam logic [4:0] OP_STU = 5'b10011;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/mem_wait_fsm.sv
// Request/wait sequencer for the data memory: issues the request pulse,
// holds the pipe while waiting for done and aborts after TIMEOUT_CYC WAIT cycles.
module mem_wait_fsm
   import memory_stage_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic issue_i,
   input  logic mem_done_i,
   output logic mem_req_o,
   output logic stall_o,
   output logic done_o,
   output logic timeout_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      mem_req_o = 1'b0;
      stall_o   = 1'b0;
      done_o    = 1'b0;
      timeout_o = 1'b0;
      case (state_q)
         ST_IDLE: begin
            // a done pulse seen here belongs to a dropped access and is ignored
            if (issue_i) begin
               mem_req_o = 1'b1;
               stall_o   = 1'b1;
               cnt_d     = '0;
               state_d   = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (mem_done_i) begin
               done_o  = 1'b1;
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
               timeout_o = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               stall_o = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: issues LD/ST/STU to a variable-latency memory, selects the
// writeback value and registers the MEM/WB pipe. Optional MEM_ALIGN_CHECK_EN.
module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int unsigned DATA_W      = DATA_W_DEFAULT,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] instruction_in,
   input  logic [DATA_W-1:0] Xcomp_in,
   input  logic [DATA_W-1:0] RegData_in,
   input  logic [DATA_W-1:0] incrPC_in,
   input  logic              RegWrt_in,
   input  logic              valid_in,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_done,
   output logic              stall,
   output logic [DATA_W-1:0] instruction_out,
   output logic [DATA_W-1:0] WData,
   output logic [DATA_W-1:0] incrPC_out,
   output logic              RegWrt_out,
   output logic              valid_out,
   output logic              err
);

   logic [4:0] opcode;
   logic       is_ld, is_wr, is_mem, misalign, issue;
   logic       done, timeout, kill;

   assign opcode = instruction_in[DATA_W-1 -: 5];
   assign is_ld  = (opcode == OP_LD);
   assign is_wr  = (opcode == OP_ST) || (opcode == OP_STU);
   assign is_mem = valid_in & (is_ld | is_wr);

`ifdef MEM_ALIGN_CHECK_EN
   assign misalign = is_mem & Xcomp_in[0];
`else
   assign misalign = 1'b0;
`endif

   assign issue = is_mem & ~misalign;

   mem_wait_fsm #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_fsm (
      .clk_i      (clk),
      .rst_ni     (rst),
      .issue_i    (issue),
      .mem_done_i (mem_done),
      .mem_req_o  (mem_req),
      .stall_o    (stall),
      .done_o     (done),
      .timeout_o  (timeout)
   );

   assign mem_wr    = mem_req & is_wr;
   assign mem_addr  = mem_req ? Xcomp_in   : '0;
   assign mem_wdata = mem_req ? RegData_in : '0;

   // Aborted slots still retire, but with no register write and a zero value.
   assign kill = timeout | misalign;

   logic [DATA_W-1:0] instr_q, wdata_q, incr_q, wdata_d;
   logic              regwrt_q, valid_q, err_q;

   always_comb begin
      wdata_d = Xcomp_in;
      if (kill)
         wdata_d = '0;
      else if (done & is_ld)
         wdata_d = mem_rdata;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         instr_q  <= '0;
         wdata_q  <= '0;
         incr_q   <= '0;
         regwrt_q <= 1'b0;
         valid_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         if (stall) begin
            regwrt_q <= 1'b0;
            valid_q  <= 1'b0;
         end else begin
            instr_q  <= instruction_in;
            wdata_q  <= wdata_d;
            incr_q   <= incrPC_in;
            regwrt_q <= RegWrt_in & ~kill;
            valid_q  <= valid_in;
         end
         if (kill)
            err_q <= 1'b1;
      end
   end

   assign instruction_out = instr_q;
   assign WData           = wdata_q;
   assign incrPC_out      = incr_q;
   assign RegWrt_out      = regwrt_q;
   assign valid_out       = valid_q;
   assign err             = err_q;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: driver pushes expected writebacks and
// memory requests, a responder models the memory and a monitor checks the pipe.
module tb_memory_stage;
   import memory_stage_pkg::*;

   localparam int unsigned W  = 16;
   localparam int unsigned TO = 64;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] instruction_in, Xcomp_in, RegData_in, incrPC_in;
   logic         RegWrt_in, valid_in;
   logic         mem_req, mem_wr, mem_done;
   logic [W-1:0] mem_addr, mem_wdata, mem_rdata;
   logic         stall, RegWrt_out, valid_out, err;
   logic [W-1:0] instruction_out, WData, incrPC_out;

   memory_stage #(
      .DATA_W      (W),
      .TIMEOUT_CYC (TO)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .instruction_in  (instruction_in),
      .Xcomp_in        (Xcomp_in),
      .RegData_in      (RegData_in),
      .incrPC_in       (incrPC_in),
      .RegWrt_in       (RegWrt_in),
      .valid_in        (valid_in),
      .mem_req         (mem_req),
      .mem_wr          (mem_wr),
      .mem_addr        (mem_addr),
      .mem_wdata       (mem_wdata),
      .mem_rdata       (mem_rdata),
      .mem_done        (mem_done),
      .stall           (stall),
      .instruction_out (instruction_out),
      .WData           (WData),
      .incrPC_out      (incrPC_out),
      .RegWrt_out      (RegWrt_out),
      .valid_out       (valid_out),
      .err             (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [W-1:0] instr;
      logic [W-1:0] wdata;
      logic [W-1:0] incr;
      logic         regwrt;
   } wb_t;

   typedef struct packed {
      logic         wr;
      logic [W-1:0] addr;
      logic [W-1:0] wdata;
   } req_t;

   wb_t  wb_q[$];
   req_t req_q[$];

   int           tests_run    = 0;
   int           tests_failed = 0;
   int           resp_delay   = 1;
   int           pend         = 0;
   bit           pulse_req    = 1'b0;
   logic [W-1:0] resp_rdata   = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Memory responder: done arrives resp_delay cycles after the request.
   initial begin
      req_t r;
      mem_done  = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         mem_done  = 1'b0;
         mem_rdata = '0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               mem_done  = 1'b1;
               mem_rdata = resp_rdata;
            end
         end else if (pulse_req) begin
            mem_done  = 1'b1;
            pulse_req = 1'b0;
         end
         #2;
         if (mem_req === 1'b1) begin
            if (req_q.size() == 0) begin
               chk("unexpected_req", {31'd0, mem_req}, 32'd0);
            end else begin
               r = req_q.pop_front();
               chk("mem_wr", {31'd0, mem_wr}, {31'd0, r.wr});
               chk("mem_addr", {16'd0, mem_addr}, {16'd0, r.addr});
               if (r.wr) chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, r.wdata});
               pend = (resp_delay > 0) ? resp_delay : 0;
            end
         end
      end
   end

   // Writeback monitor
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (valid_out === 1'b1) begin
            if (wb_q.size() == 0) begin
               chk("unexpected_wb", {31'd0, valid_out}, 32'd0);
            end else begin
               e = wb_q.pop_front();
               chk("wb_instr", {16'd0, instruction_out}, {16'd0, e.instr});
               chk("wb_wdata", {16'd0, WData}, {16'd0, e.wdata});
               chk("wb_incrpc", {16'd0, incrPC_out}, {16'd0, e.incr});
               chk("wb_regwrt", {31'd0, RegWrt_out}, {31'd0, e.regwrt});
            end
         end
      end
   end

   task automatic drive(input logic [W-1:0] instr, input logic [W-1:0] x,
                        input logic [W-1:0] rd, input logic [W-1:0] pc,
                        input logic rw, input logic v,
                        input bit has_req, input logic wr,
                        input logic [W-1:0] exp_wd, input logic exp_rw,
                        input int exp_stall);
      int stalls;
      @(negedge clk);
      instruction_in = instr;
      Xcomp_in       = x;
      RegData_in     = rd;
      incrPC_in      = pc;
      RegWrt_in      = rw;
      valid_in       = v;
      if (has_req) req_q.push_back('{wr, x, rd});
      if (v) wb_q.push_back('{instr, exp_wd, pc, exp_rw});
      stalls = 0;
      forever begin
         #3;
         if (stall !== 1'b1) break;
         stalls++;
         if (stalls > 200) break;
         @(negedge clk);
      end
      chk("stall_cycles", stalls, exp_stall);
      @(posedge clk);
      #1;
      valid_in       = 1'b0;
      RegWrt_in      = 1'b0;
      instruction_in = '0;
      Xcomp_in       = '0;
      RegData_in     = '0;
      incrPC_in      = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      instruction_in = '0; Xcomp_in = '0; RegData_in = '0; incrPC_in = '0;
      RegWrt_in = 1'b0; valid_in = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("rst_wdata", {16'd0, WData}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_stall", {31'd0, stall}, 32'd0);
      rst = 1'b1;

      // ALU op, then back-to-back memory ops
      drive(16'hDA21, 16'h1234, 16'h0000, 16'h0102, 1'b1, 1'b1, 0, 1'b0, 16'h1234, 1'b1, 0);
      resp_delay = 3; resp_rdata = 16'hBEEF;
      drive(16'h8C20, 16'h0040, 16'h0000, 16'h0104, 1'b1, 1'b1, 1, 1'b0, 16'hBEEF, 1'b1, 3);
      resp_delay = 1;
      drive(16'h8420, 16'h0010, 16'h00AA, 16'h0106, 1'b0, 1'b1, 1, 1'b1, 16'h0010, 1'b0, 1);
      resp_delay = 2;
      drive(16'h9C40, 16'h0022, 16'h0055, 16'h0108, 1'b1, 1'b1, 1, 1'b1, 16'h0022, 1'b1, 2);
      resp_delay = 1; resp_rdata = 16'h1357;
      drive(16'h8C60, 16'h0030, 16'h0000, 16'h010A, 1'b1, 1'b1, 1, 1'b0, 16'h1357, 1'b1, 1);
      // Near-miss opcode and an invalid LD slot must not touch memory
      drive(16'h9400, 16'h0ABC, 16'h0000, 16'h010C, 1'b1, 1'b1, 0, 1'b0, 16'h0ABC, 1'b1, 0);
      drive(16'h8C00, 16'h0070, 16'h0000, 16'h010E, 1'b1, 1'b0, 0, 1'b0, 16'h0000, 1'b0, 0);
      chk("err_before_timeout", {31'd0, err}, 32'd0);

      // Timeout: no done ever arrives
      resp_delay = -1;
      drive(16'h8C80, 16'h0050, 16'h0000, 16'h0110, 1'b1, 1'b1, 1, 1'b0, 16'h0000, 1'b0, 64);
      chk("err_after_timeout", {31'd0, err}, 32'd1);
      #3;
      chk("stall_after_timeout", {31'd0, stall}, 32'd0);

      // Reset mid-access, then a stray done
      @(negedge clk);
      Xcomp_in = 16'h0090; instruction_in = 16'h8CC0; valid_in = 1'b1; RegWrt_in = 1'b1;
      req_q.push_back('{1'b0, 16'h0090, 16'h0000});
      repeat (2) @(negedge clk);
      valid_in = 1'b0; RegWrt_in = 1'b0; instruction_in = '0; Xcomp_in = '0;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_err", {31'd0, err}, 32'd0);
      chk("midrst_valid_out", {31'd0, valid_out}, 32'd0);
      chk("midrst_regwrt", {31'd0, RegWrt_out}, 32'd0);
      chk("midrst_instr", {16'd0, instruction_out}, 32'd0);
      #3;
      chk("midrst_stall", {31'd0, stall}, 32'd0);
      chk("midrst_req", {31'd0, mem_req}, 32'd0);
      rst = 1'b1;
      pulse_req = 1'b1;
      repeat (3) @(negedge clk);
      #3;
      chk("stray_done_stall", {31'd0, stall}, 32'd0);
      chk("stray_done_valid", {31'd0, valid_out}, 32'd0);

      resp_delay = 2; resp_rdata = 16'h2468;
      drive(16'h8CA0, 16'h0060, 16'h0000, 16'h0112, 1'b1, 1'b1, 1, 1'b0, 16'h2468, 1'b1, 2);

      // Odd address
`ifdef MEM_ALIGN_CHECK_EN
      drive(16'h8CE0, 16'h0041, 16'h0000, 16'h0114, 1'b1, 1'b1, 0, 1'b0, 16'h0000, 1'b0, 0);
      chk("err_misalign", {31'd0, err}, 32'd1);
`else
      resp_delay = 2; resp_rdata = 16'h0F0F;
      drive(16'h8CE0, 16'h0041, 16'h0000, 16'h0114, 1'b1, 1'b1, 1, 1'b0, 16'h0F0F, 1'b1, 2);
      chk("err_odd_addr", {31'd0, err}, 32'd0);
`endif

      repeat (4) @(negedge clk);
      chk("wb_queue_drained", wb_q.size(), 32'd0);
      chk("req_queue_drained", req_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
